// File: rtl/key_count_bcd_pkg.sv
// Shared constants and types for the key/count/BCD front end.
// The segment table is only referenced when KEY_COUNT_BCD_SEG_EN is defined.
package key_count_bcd_pkg;

   localparam logic [3:0] DEF_IDLE_CODE = 4'h0;

   typedef logic [3:0] bcd_digit_t;

   // Active-low segments, bit0 = a ... bit6 = g
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_TABLE [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   function automatic logic [6:0] seg_decode(input bcd_digit_t d);
      return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounce of one 4-bit key-code stream: sample register, saturating stability
// counter and debounced output that follows only after DEBOUNCE_CYCLES stable edges.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter logic [3:0]  IDLE_CODE       = 4'h0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] raw,
   output logic [3:0] db,
   output logic       chg
);

   localparam int CW = 16;

   logic [3:0]    sample;
   logic [CW-1:0] stab;
   logic          load;

   // The capture edge is the first stable edge, so the load fires when the
   // counter has seen DEBOUNCE_CYCLES-2 further matching edges.
   assign load = (raw == sample) && (stab == CW'(DEBOUNCE_CYCLES - 2));
   assign chg  = load && (sample != db) && (sample != IDLE_CODE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample <= IDLE_CODE;
         stab   <= '0;
         db     <= IDLE_CODE;
      end else begin
         sample <= raw;
         if (raw != sample)
            stab <= '0;
         else if (stab != {CW{1'b1}})
            stab <= stab + 1'b1;
         if (load)
            db <= sample;
      end
   end

endmodule

// File: rtl/key_count_bcd.sv
// Keypad front end: debounced command key with press strobe, quantity counter,
// and binary-to-BCD display digits. KEY_COUNT_BCD_SEG_EN adds 7-segment outputs.
module key_count_bcd
   import key_count_bcd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned COUNT_MAX       = 9,
   parameter logic [3:0]  IDLE_CODE       = DEF_IDLE_CODE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_raw,
   input  logic [3:0] cnt_raw,
   input  logic       clr_count,
   input  logic [7:0] bin_in,
   output logic [3:0] key_db,
   output logic       key_pulse,
   output logic [3:0] count,
   output logic [3:0] bcd_h,
   output logic [3:0] bcd_t,
   output logic [3:0] bcd_o
`ifdef KEY_COUNT_BCD_SEG_EN
  ,output logic [6:0] seg_h,
   output logic [6:0] seg_t,
   output logic [6:0] seg_o
`endif
);

   logic       key_chg, key_chg_q;
   logic [3:0] cnt_db;
   logic       cnt_chg;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_CODE(IDLE_CODE)) u_key_db (
      .clk(clk), .reset(reset), .raw(key_raw), .db(key_db), .chg(key_chg)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_CODE(IDLE_CODE)) u_cnt_db (
      .clk(clk), .reset(reset), .raw(cnt_raw), .db(cnt_db), .chg(cnt_chg)
   );

   // Strobe lands one cycle after key_db shows the new code
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_chg_q <= 1'b0;
         key_pulse <= 1'b0;
      end else begin
         key_chg_q <= key_chg;
         key_pulse <= key_chg_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= 4'd0;
      else if (clr_count)
         count <= 4'd0;
      else if (cnt_chg && (cnt_db == IDLE_CODE))
         count <= (count == 4'(COUNT_MAX)) ? 4'd0 : count + 4'd1;
   end

   // Shift-add-3: 8 binary bits shifted up through three BCD nibbles
   logic [19:0] sh;
   always_comb begin
      sh = {12'd0, bin_in};
      for (int i = 0; i < 8; i++) begin
         if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
         if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
         if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
         sh = sh << 1;
      end
   end

   assign bcd_h = sh[19:16];
   assign bcd_t = sh[15:12];
   assign bcd_o = sh[11:8];

`ifdef KEY_COUNT_BCD_SEG_EN
   assign seg_h = seg_decode(bcd_h);
   assign seg_t = seg_decode(bcd_t);
   assign seg_o = seg_decode(bcd_o);
`endif

endmodule

// File: tb/tb_key_count_bcd.sv
// Bench for key_count_bcd: run-length debounce model, per-cycle compare,
// directed literal checks and randomized key/count/display traffic.
module tb_key_count_bcd;

   localparam int       DB   = 4;
   localparam int       CMAX = 3;
   localparam bit [3:0] IDLE = 4'h0;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] key_raw = 4'h0, cnt_raw = 4'h0;
   logic       clr_count = 1'b0;
   logic [7:0] bin_in = 8'd0;
   logic [3:0] key_db, count, bcd_h, bcd_t, bcd_o;
   logic       key_pulse;
`ifdef KEY_COUNT_BCD_SEG_EN
   logic [6:0] seg_h, seg_t, seg_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   key_count_bcd #(.DEBOUNCE_CYCLES(DB), .COUNT_MAX(CMAX), .IDLE_CODE(IDLE)) dut (
      .clk(clk), .reset(reset), .key_raw(key_raw), .cnt_raw(cnt_raw),
      .clr_count(clr_count), .bin_in(bin_in), .key_db(key_db),
      .key_pulse(key_pulse), .count(count),
      .bcd_h(bcd_h), .bcd_t(bcd_t), .bcd_o(bcd_o)
`ifdef KEY_COUNT_BCD_SEG_EN
     ,.seg_h(seg_h), .seg_t(seg_t), .seg_o(seg_o)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural model: a debounced value follows raw once raw has held the
   // same code for DB consecutive edges (reset counts as one idle edge).
   int         k_run, c_run;
   logic [3:0] k_last, c_last, m_key_db, m_cnt_db, m_count;
   logic       m_pulse, pend;

   always begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         k_run = 1; c_run = 1; k_last = IDLE; c_last = IDLE;
         m_key_db = IDLE; m_cnt_db = IDLE; m_count = 4'd0;
         m_pulse = 1'b0; pend = 1'b0;
      end else begin
         m_pulse = pend;
         pend = 1'b0;
         if (key_raw == k_last) begin
            if (k_run < 1000000) k_run++;
         end else begin
            k_run = 1; k_last = key_raw;
         end
         if (k_run == DB && k_last != m_key_db) begin
            m_key_db = k_last;
            pend = (k_last != IDLE);
         end
         if (cnt_raw == c_last) begin
            if (c_run < 1000000) c_run++;
         end else begin
            c_run = 1; c_last = cnt_raw;
         end
         if (clr_count)
            m_count = 4'd0;
         else if (c_run == DB && m_cnt_db == IDLE && c_last != IDLE)
            m_count = (m_count == CMAX) ? 4'd0 : m_count + 4'd1;
         if (c_run == DB) m_cnt_db = c_last;
      end
   end

   function automatic logic [6:0] seg_ref(input int d);
      case (d)
         0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
         3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
         6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
         9: return 7'b0010000; default: return 7'b1111111;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model
   always begin
      @(negedge clk);
      chk("key_db",    int'(key_db),    int'(m_key_db));
      chk("key_pulse", int'(key_pulse), int'(m_pulse));
      chk("count",     int'(count),     int'(m_count));
      chk("bcd_h",     int'(bcd_h),     int'(bin_in) / 100);
      chk("bcd_t",     int'(bcd_t),     (int'(bin_in) / 10) % 10);
      chk("bcd_o",     int'(bcd_o),     int'(bin_in) % 10);
`ifdef KEY_COUNT_BCD_SEG_EN
      chk("seg_h", int'(seg_h), int'(seg_ref(int'(bin_in) / 100)));
      chk("seg_t", int'(seg_t), int'(seg_ref((int'(bin_in) / 10) % 10)));
      chk("seg_o", int'(seg_o), int'(seg_ref(int'(bin_in) % 10)));
`endif
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int bin_tab [6] = '{0, 9, 10, 99, 100, 255};
   int bcd_tab [6] = '{0, 9, 10, 99, 100, 255};

   initial begin
      int k_hold, c_hold;
      tick(2);
      @(negedge clk);
      chk("rst_key_db", int'(key_db), 0);
      chk("rst_pulse",  int'(key_pulse), 0);
      chk("rst_count",  int'(count), 0);
      tick();
      reset = 1'b1;
      tick();

      // Clean press: key_db on the 4th edge, strobe on the 5th
      key_raw = 4'hF;
      tick(3);
      @(negedge clk); chk("db_edge3", int'(key_db), 0);
      tick();
      @(negedge clk); chk("db_edge4", int'(key_db), 15);
      chk("pulse_edge4", int'(key_pulse), 0);
      tick();
      @(negedge clk); chk("pulse_edge5", int'(key_pulse), 1);
      tick();
      @(negedge clk); chk("pulse_edge6", int'(key_pulse), 0);
      key_raw = 4'h0;
      tick(6);

      // Glitch of 3 edges is rejected
      key_raw = 4'h3;
      tick(3);
      key_raw = 4'h0;
      for (int i = 0; i < 8; i++) begin
         tick();
         @(negedge clk);
         chk("glitch_db", int'(key_db), 0);
         chk("glitch_pulse", int'(key_pulse), 0);
      end

      // Counter presses, wrap after COUNT_MAX
      for (int i = 1; i <= 4; i++) begin
         cnt_raw = 4'hC;
         tick(6);
         @(negedge clk); chk("count_press", int'(count), i % (CMAX + 1));
         cnt_raw = 4'h0;
         tick(6);
      end
      cnt_raw = 4'hC;
      tick(20);
      @(negedge clk); chk("count_long_hold", int'(count), 1);
      cnt_raw = 4'h0;
      tick(6);

      // Clear on the same edge as an increment wins
      cnt_raw = 4'hC;
      tick(3);
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      @(negedge clk); chk("count_clr_prio", int'(count), 0);
      tick(4);
      @(negedge clk); chk("count_clr_hold", int'(count), 0);
      cnt_raw = 4'h0;
      tick(6);

      // Display digits
      for (int i = 0; i < 6; i++) begin
         bin_in = 8'(bin_tab[i]);
         #1;
         chk("bcd_lit", int'({bcd_h, bcd_t, bcd_o}),
             (i == 0) ? 'h000 : (i == 1) ? 'h009 : (i == 2) ? 'h010 :
             (i == 3) ? 'h099 : (i == 4) ? 'h100 : 'h255);
         bcd_tab[i] = int'(bcd_h);
      end
`ifdef KEY_COUNT_BCD_SEG_EN
      chk("seg_h_255", int'(seg_h), int'(7'b0100100));
`endif
      tick();

      // Random traffic with an asynchronous reset mid-run
      k_hold = 0; c_hold = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (k_hold == 0) begin
            case ($urandom_range(0, 4))
               0, 1: key_raw = 4'h0;
               2: key_raw = 4'h3;
               3: key_raw = 4'h5;
               default: key_raw = 4'hF;
            endcase
            k_hold = $urandom_range(1, 8);
         end
         if (c_hold == 0) begin
            case ($urandom_range(0, 2))
               0: cnt_raw = 4'h0;
               1: cnt_raw = 4'hC;
               default: cnt_raw = 4'h7;
            endcase
            c_hold = $urandom_range(1, 9);
         end
         k_hold--; c_hold--;
         clr_count = ($urandom_range(0, 40) == 0);
         bin_in = 8'($urandom);
         if (cyc == 1500 || cyc == 2200) begin
            #1 reset = 1'b0;
            tick();
            reset = 1'b1;
         end else begin
            tick();
         end
      end
      clr_count = 1'b0;
      tick(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/key_count_bcd.md
Name: key_count_bcd

Overview:
- Front-end helper for the vending-machine controller.
- Debounces two raw 4-bit keypad code streams: the command key and the quantity "count" key.
- Counts debounced count-key presses to produce the quantity.
- Converts an 8-bit display value to three BCD digits for the seven-segment drivers.
- Sits between the keypad scanners and the controller FSM / display path.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable clk edges required before a debounced output changes (legal 2..65535).
- COUNT_MAX, 9, highest count value before wrap (legal 1..15).
- IDLE_CODE, 4'h0, key code meaning "no key pressed".

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- key_raw  input  4  raw command key code from the keypad scanner
- cnt_raw  input  4  raw count-key code from the count scanner
- clr_count  input  1  synchronous clear of count
- bin_in  input  8  unsigned value to display
- key_db  output  4  debounced command key code
- key_pulse  output  1  one-cycle strobe when key_db changes to a non-idle code
- count  output  4  quantity count
- bcd_h  output  4  hundreds digit of bin_in
- bcd_t  output  4  tens digit of bin_in
- bcd_o  output  4  ones digit of bin_in

Behaviour:
- Reset (reset=0, asynchronous): key_db=IDLE_CODE, key_pulse=0, count=0; all debounce stability counters and sample registers cleared (samples = IDLE_CODE).
- Debounce, per stream, implemented identically for key_raw and cnt_raw:
  - Sample register captures raw on every edge.
  - Stability counter resets to 0 whenever raw differs from the sample; otherwise it increments, saturating.
  - The debounced value is loaded with the sample on the edge where raw has been equal to the sample for DEBOUNCE_CYCLES consecutive edges.
  - A raw glitch shorter than DEBOUNCE_CYCLES edges never reaches the output.
  - A change from one non-idle code directly to another also requires the full stability time.
- key_pulse: registered; asserted for exactly one cycle, on the cycle after key_db takes a new value that is != IDLE_CODE. Re-pressing the same key requires key_db to pass through IDLE_CODE first.
- Counter:
  - Increments on the cycle where the debounced cnt stream changes from IDLE_CODE to any non-idle code.
  - After COUNT_MAX it wraps to 0.
  - clr_count=1 forces count to 0 on the next edge and has priority over an increment in the same cycle.
  - Holding the count key gives only one increment.
- BCD conversion:
  - Purely combinational from bin_in (shift-add-3 or equivalent); zero latency.
  - bcd_h range 0..2; bcd_t and bcd_o range 0..9; bin_in=0 gives 0/0/0.
  - Not affected by reset.
- All state is updated on rising clk only, apart from the asynchronous reset.
- Reset asserted mid-debounce discards the partial stability count.

Optional Feature:
- Macro: KEY_COUNT_BCD_SEG_EN.
- When defined, adds three outputs: seg_h, seg_t, seg_o, each 7 bits.
  - Combinational decode of bcd_h/bcd_t/bcd_o.
  - Active-low segments; bit0=a ... bit6=g.
  - 0→7'b1000000, 1→7'b1111001, 8→7'b0000000; codes 10..15 give blank (7'b1111111).
- When undefined, these ports and the decode logic are absent; all other behaviour is identical.

Decomposition:
- Package key_count_bcd_pkg:
  - IDLE_CODE default.
  - Digit-to-segment constant table for codes 0..9 plus a blank pattern.
  - Typedef bcd_digit_t, 4-bit.
- One natural sub-module: key_debounce.
  - Holds the 4-bit sample register, stability counter and debounced output.
  - Instantiated twice, once per raw stream.
- Counter and BCD conversion stay in the top level.

Test Plan:
- Reset → key_db=0, key_pulse=0, count=0.
- Debounce: release reset, hold key_raw=4'hF for 4 edges → key_db=4'hF on the 4th edge; key_pulse=1 for one cycle on the next cycle.
- Glitch rejection: key_raw=4'h3 for 3 edges, then 4'h0 → key_db stays 0 and key_pulse never asserts.
- Counter: three clean cnt_raw presses (4'hC held 6 cycles, then 4'h0 held 6 cycles) → count=1,2,3; one long 20-cycle hold → exactly one increment.
- Counter boundaries: with COUNT_MAX=3, a 4th press → count=0; clr_count asserted together with a press edge → count=0.
- BCD: bin_in = 0, 9, 10, 99, 100, 255 → h/t/o = 0/0/0, 0/0/9, 0/1/0, 0/9/9, 1/0/0, 2/5/5; with KEY_COUNT_BCD_SEG_EN defined, 255 → seg_h=7'b0100100.
